// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin sharing of one pipelined 16x16 multiplier.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      per-requester handshake (NREQ bits)
//   req_a, req_b             packed 16-bit operands, lane i at [16i+:16]
//   rsp_valid/rsp_id/rsp_p   tagged product, one pulse per accepted pair
//   busy                     any pipeline stage occupied
module mult_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_p,
    output logic                 busy
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gid;
    logic           gnt_any;
    logic [15:0]    a_sel;
    logic [15:0]    b_sel;

    // Scan upward from ptr, wrapping at NREQ; first valid lane wins.
    always_comb begin
        int idx;
        idx       = 0;
        req_ready = '0;
        gid       = '0;
        gnt_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_any && req_valid[idx]) begin
                gnt_any        = 1'b1;
                req_ready[idx] = 1'b1;
                gid            = IDW'(idx);
            end
        end
    end

    assign a_sel = req_a[16*gid +: 16];
    assign b_sel = req_b[16*gid +: 16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
        end
    end

    // Stage 1 captures the raw operands; the multiply is formed after it.
    logic           v1;
    logic [IDW-1:0] id1;
    logic [15:0]    a1;
    logic [15:0]    b1;
    logic [31:0]    mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            id1 <= '0;
            a1  <= '0;
            b1  <= '0;
        end else begin
            v1 <= gnt_any;
            if (gnt_any) begin
                id1 <= gid;
                a1  <= a_sel;
                b1  <= b_sel;
            end
        end
    end

    assign mul = 32'(a1) * 32'(b1);

    generate
        if (LAT == 1) begin : g_lat1
            // a1/b1/id1 only load on a transfer, so outputs already hold.
            assign rsp_valid = v1;
            assign rsp_id    = id1;
            assign rsp_p     = mul;
            assign busy      = v1;
        end else begin : g_latn
            logic [LAT:2]   vq;
            logic [IDW-1:0] iq [2:LAT];
            logic [31:0]    pq [2:LAT];
            logic [LAT:2]   sv;
            logic [IDW-1:0] si [2:LAT];
            logic [31:0]    sp [2:LAT];

            // Source of each stage: stage 2 from stage 1, then chained.
            always_comb begin
                sv[2] = v1;
                si[2] = id1;
                sp[2] = mul;
                for (int k = 3; k <= LAT; k++) begin
                    sv[k] = vq[k-1];
                    si[k] = iq[k-1];
                    sp[k] = pq[k-1];
                end
            end

            // Data registers only load behind a valid bit, so bubbles
            // leave the last product and tag untouched on the outputs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vq <= '0;
                    for (int k = 2; k <= LAT; k++) begin
                        iq[k] <= '0;
                        pq[k] <= '0;
                    end
                end else begin
                    for (int k = 2; k <= LAT; k++) begin
                        vq[k] <= sv[k];
                        if (sv[k]) begin
                            iq[k] <= si[k];
                            pq[k] <= sp[k];
                        end
                    end
                end
            end

            assign rsp_valid = vq[LAT];
            assign rsp_id    = iq[LAT];
            assign rsp_p     = pq[LAT];
            assign busy      = v1 | (|vq);
        end
    endgenerate

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter: directed table plus randomized scoreboard checks
// for mult_rr_arbiter (NREQ=4/LAT=2, and NREQ=3 with LAT=1 and LAT=4).
module tb_mult_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [3:0]  rv;
    logic [63:0] ra, rb;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  oid;
    logic [31:0] op;
    logic        obusy;

    logic [2:0]  rv3;
    logic [47:0] ra3, rb3;
    logic [2:0]  rdy1, rdy2;
    logic        ov1, ov2;
    logic [1:0]  oid1, oid2;
    logic [31:0] op1, op2;
    logic        ob1, ob2;

    mult_rr_arbiter #(.NREQ(4), .LAT(2), .IDW(2)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv), .req_a(ra), .req_b(rb),
        .req_ready(rdy), .rsp_valid(ov), .rsp_id(oid), .rsp_p(op),
        .busy(obusy)
    );

    mult_rr_arbiter #(.NREQ(3), .LAT(1), .IDW(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_a(ra3), .req_b(rb3),
        .req_ready(rdy1), .rsp_valid(ov1), .rsp_id(oid1), .rsp_p(op1),
        .busy(ob1)
    );

    mult_rr_arbiter #(.NREQ(3), .LAT(4), .IDW(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_a(ra3), .req_b(rb3),
        .req_ready(rdy2), .rsp_valid(ov2), .rsp_id(oid2), .rsp_p(op2),
        .busy(ob2)
    );

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rv  = '0;
        rv3 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rnd16();
        int s;
        s = $urandom_range(0, 7);
        if (s == 0) return 16'h0000;
        if (s == 1) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    typedef struct {
        logic [3:0]  v;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rdy;
        logic        rv;
        logic [1:0]  id;
        logic [31:0] p;
        logic        busy;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] p;
        int          due;
    } exp_t;

    vec_t tbl [15];
    exp_t q1 [$];
    exp_t q2 [$];

    initial begin
        tbl[0]  = '{4'b0100, 16'h1234, 16'h0010, 4'b0100, 1'b0, 2'd0, 32'h0, 1'b0};
        tbl[1]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1};
        tbl[2]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b1, 2'd2, 32'h00012340, 1'b1};
        tbl[3]  = '{4'b1111, 16'hFFFF, 16'hFFFF, 4'b1000, 1'b0, 2'd2, 32'h00012340, 1'b0};
        tbl[4]  = '{4'b1111, 16'hFFFF, 16'h0000, 4'b0001, 1'b0, 2'd2, 32'h00012340, 1'b1};
        tbl[5]  = '{4'b1111, 16'h8000, 16'h0002, 4'b0010, 1'b1, 2'd3, 32'hFFFE0001, 1'b1};
        tbl[6]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b1, 2'd0, 32'h00000000, 1'b1};
        tbl[7]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b1, 2'd1, 32'h00010000, 1'b1};
        tbl[8]  = '{4'b0100, 16'h0003, 16'h0005, 4'b0100, 1'b0, 2'd1, 32'h00010000, 1'b0};
        tbl[9]  = '{4'b1010, 16'h0007, 16'h0009, 4'b1000, 1'b0, 2'd1, 32'h00010000, 1'b1};
        tbl[10] = '{4'b1010, 16'h00FF, 16'h0101, 4'b0010, 1'b1, 2'd2, 32'h0000000F, 1'b1};
        tbl[11] = '{4'b1010, 16'h0007, 16'h0009, 4'b1000, 1'b1, 2'd3, 32'h0000003F, 1'b1};
        tbl[12] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b1, 2'd1, 32'h0000FFFF, 1'b1};
        tbl[13] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b1, 2'd3, 32'h0000003F, 1'b1};
        tbl[14] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 1'b0, 2'd3, 32'h0000003F, 1'b0};

        rst = 1'b1;
        rv  = 4'b1010;
        ra  = '0;
        rb  = '0;
        rv3 = '0;
        ra3 = '0;
        rb3 = '0;

        // Reset state, with ready still following valid from ptr 0.
        #2;
        chk("reset ready", 32'(rdy), 32'h2);
        chk("reset rsp_valid", 32'(ov), 32'h0);
        chk("reset rsp_id", 32'(oid), 32'h0);
        chk("reset rsp_p", op, 32'h0);
        chk("reset busy", 32'(obusy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rv  = '0;

        // Directed table: single request, extremes, skip/wrap, hold.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rv = tbl[i].v;
            ra = {4{tbl[i].a}};
            rb = {4{tbl[i].b}};
            #1;
            chk($sformatf("row%0d ready", i), 32'(rdy), 32'(tbl[i].rdy));
            chk($sformatf("row%0d rsp_valid", i), 32'(ov), 32'(tbl[i].rv));
            chk($sformatf("row%0d rsp_id", i), 32'(oid), 32'(tbl[i].id));
            chk($sformatf("row%0d rsp_p", i), op, tbl[i].p);
            chk($sformatf("row%0d busy", i), 32'(obusy), 32'(tbl[i].busy));
        end

        // Full contention from reset: strict 0,1,2,3 rotation.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c < 8) begin
                rv = 4'hF;
                for (int i = 0; i < 4; i++) begin
                    ra[16*i +: 16] = 16'(i + 1);
                    rb[16*i +: 16] = 16'(c + 2);
                end
            end else begin
                rv = 4'h0;
            end
            #1;
            if (c < 8) begin
                chk($sformatf("cont%0d ready", c), 32'(rdy),
                    32'(1 << (c % 4)));
            end
            if (c >= 2 && c <= 9) begin
                chk($sformatf("cont%0d rsp_valid", c), 32'(ov), 32'h1);
                chk($sformatf("cont%0d rsp_id", c), 32'(oid),
                    32'((c - 2) % 4));
                chk($sformatf("cont%0d rsp_p", c), op,
                    32'(((c - 2) % 4 + 1) * c));
            end else begin
                chk($sformatf("cont%0d rsp_valid", c), 32'(ov), 32'h0);
            end
        end

        // Reset with two operations in flight.
        do_reset();
        @(negedge clk);
        rv = 4'b0001;
        ra[15:0] = 16'h0011;
        rb[15:0] = 16'h0011;
        #1;
        chk("mid ready0", 32'(rdy), 32'h1);
        @(negedge clk);
        rv = 4'b0010;
        ra[31:16] = 16'h0022;
        rb[31:16] = 16'h0022;
        #1;
        chk("mid ready1", 32'(rdy), 32'h2);
        @(negedge clk);
        rv = 4'b0000;
        #1;
        chk("mid busy before", 32'(obusy), 32'h1);
        chk("mid rsp before", 32'(ov), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rsp_valid at rst", 32'(ov), 32'h0);
        chk("mid busy at rst", 32'(obusy), 32'h0);
        chk("mid rsp_p at rst", op, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mid stale%0d", c), 32'(ov), 32'h0);
        end
        @(negedge clk);
        rv = 4'b1000;
        ra[63:48] = 16'h0ABC;
        rb[63:48] = 16'h0003;
        #1;
        chk("mid post ready", 32'(rdy), 32'h8);
        @(negedge clk);
        rv = 4'b0000;
        #1;
        chk("mid post early", 32'(ov), 32'h0);
        @(negedge clk);
        #1;
        chk("mid post rsp_valid", 32'(ov), 32'h1);
        chk("mid post rsp_id", 32'(oid), 32'h3);
        chk("mid post rsp_p", op, 32'h00002034);
        @(negedge clk);
        #1;
        chk("mid post single", 32'(ov), 32'h0);

        // Randomized traffic on NREQ=3, LAT=1 and LAT=4.
        do_reset();
        begin
            int          mptr;
            int          g;
            int          j;
            logic        ev;
            logic [2:0]  pend;
            logic [2:0]  erdy;
            logic [15:0] pa [3];
            logic [15:0] pb [3];
            mptr = 0;
            pend = '0;
            for (int i = 0; i < 3; i++) begin
                pa[i] = '0;
                pb[i] = '0;
            end
            for (int cyc = 0; cyc < 300; cyc++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (pend[i]) begin
                        if ($urandom_range(0, 9) == 0) pend[i] = 1'b0;
                    end else if (cyc < 290 && $urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        pa[i]   = rnd16();
                        pb[i]   = rnd16();
                    end
                end
                rv3 = pend;
                for (int i = 0; i < 3; i++) begin
                    ra3[16*i +: 16] = pa[i];
                    rb3[16*i +: 16] = pb[i];
                end
                g = -1;
                for (int k = 0; k < 3; k++) begin
                    j = (mptr + k) % 3;
                    if (g < 0 && pend[j]) g = j;
                end
                erdy = (g >= 0) ? 3'(1 << g) : 3'b000;
                #1;
                chk($sformatf("rnd%0d lat1 ready", cyc), 32'(rdy1), 32'(erdy));
                chk($sformatf("rnd%0d lat4 ready", cyc), 32'(rdy2), 32'(erdy));

                ev = (q1.size() > 0) && (q1[0].due == cyc);
                chk($sformatf("rnd%0d lat1 rsp_valid", cyc), 32'(ov1), 32'(ev));
                if (ev) begin
                    chk($sformatf("rnd%0d lat1 rsp_id", cyc), 32'(oid1),
                        32'(q1[0].id));
                    chk($sformatf("rnd%0d lat1 rsp_p", cyc), op1, q1[0].p);
                    void'(q1.pop_front());
                end
                ev = (q2.size() > 0) && (q2[0].due == cyc);
                chk($sformatf("rnd%0d lat4 rsp_valid", cyc), 32'(ov2), 32'(ev));
                if (ev) begin
                    chk($sformatf("rnd%0d lat4 rsp_id", cyc), 32'(oid2),
                        32'(q2[0].id));
                    chk($sformatf("rnd%0d lat4 rsp_p", cyc), op2, q2[0].p);
                    void'(q2.pop_front());
                end

                if (g >= 0) begin
                    q1.push_back('{g, 32'(pa[g]) * 32'(pb[g]), cyc + 1});
                    q2.push_back('{g, 32'(pa[g]) * 32'(pb[g]), cyc + 4});
                    mptr    = (g + 1) % 3;
                    pend[g] = 1'b0;
                end
            end
            chk("lat1 drained", 32'(q1.size()), 32'h0);
            chk("lat4 drained", 32'(q2.size()), 32'h0);
            chk("lat1 idle busy", 32'(ob1), 32'h0);
            chk("lat4 idle busy", 32'(ob2), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
